// File: rtl/dcache_mem_ctrl_pkg.sv
// rtl/dcache_mem_ctrl_pkg.sv - line geometry, FSM encoding and RAM timing shared with DCache
package dcache_mem_ctrl_pkg;

  localparam int BLOCK_WIDTH    = 4;
  localparam int BLOCK_SIZE     = 2 ** BLOCK_WIDTH;
  localparam int LINE_BITS      = BLOCK_SIZE * 8;
  localparam int RAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_mem_ctrl_line_byte_shifter.sv
// rtl/dcache_mem_ctrl_line_byte_shifter.sv - line register with parallel load, byte deposit and byte select
module dcache_mem_ctrl_line_byte_shifter
  import dcache_mem_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_load,
  input  logic [LINE_BITS-1:0]   i_load_data,
  input  logic                   i_wr_en,
  input  logic [BLOCK_WIDTH-1:0] i_wr_idx,
  input  logic [7:0]             i_wr_byte,
  input  logic [BLOCK_WIDTH-1:0] i_rd_idx,
  output logic [7:0]             o_rd_byte,
  output logic [LINE_BITS-1:0]   o_line_nxt
);

  logic [LINE_BITS-1:0] r_line;
  logic [LINE_BITS-1:0] w_line_nxt;

  // o_line_nxt exposes the line including this cycle's deposit so the final byte is visible at once
  always_comb begin
    w_line_nxt = r_line;
    if (i_wr_en) begin
      w_line_nxt[{i_wr_idx, 3'b000} +: 8] = i_wr_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_data;
    end else begin
      r_line <= w_line_nxt;
    end
  end

  assign o_rd_byte  = r_line[{i_rd_idx, 3'b000} +: 8];
  assign o_line_nxt = w_line_nxt;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// rtl/dcache_mem_ctrl.sv - DCache miss responder serialising line fills/write-backs onto a byte RAM; DCACHE_MEM_CTRL_PERF_EN adds completion counters
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
(
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   missIn,
  input  logic [31:BLOCK_WIDTH]  missAddrIn,
  input  logic                   readWriteIn,
  input  logic [LINE_BITS-1:0]   writeBackIn,
  output logic                   memDataValid,
  output logic [31:BLOCK_WIDTH]  memAddr,
  output logic [LINE_BITS-1:0]   memDataOut,
  output logic                   acceptWrite,
  input  logic [7:0]             ramDataIn,
  output logic [7:0]             ramDataOut,
  output logic [31:0]            ramAddr,
  output logic                   ramWrite
`ifdef DCACHE_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]            fillCount,
  output logic [31:0]            writeBackCount
`endif
);

  localparam int CW = BLOCK_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0] RD_LAT   = CW'(RAM_RD_LATENCY);
  localparam logic [CW-1:0] FILL_END = CW'(BLOCK_SIZE - 1 + RAM_RD_LATENCY);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [31:BLOCK_WIDTH]  r_addr;
  logic [BLOCK_WIDTH-1:0] w_next_idx;
  logic [BLOCK_WIDTH-1:0] w_cap_idx;
  logic [7:0]             w_wb_byte;
  logic [LINE_BITS-1:0]   w_line_nxt;
  logic                   w_start;
  logic                   w_rd_step;
  logic                   w_wr_step;
  logic                   w_deposit;
  logic                   w_fill_done;
  logic                   w_wb_done;

  assign w_next_idx = r_cnt[BLOCK_WIDTH-1:0] + 1'b1;
  assign w_cap_idx  = r_cnt[BLOCK_WIDTH-1:0] - RD_LAT[BLOCK_WIDTH-1:0];

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE never looks at missIn: the cache reacts to the pulse combinationally
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (missIn) w_state_nxt = readWriteIn ? ST_READ : ST_WRITE;
      ST_READ:  if (r_cnt == FILL_END) w_state_nxt = ST_DONE;
      ST_WRITE: if (r_cnt == LAST_IDX) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // In READ r_cnt runs one past the last address to collect the byte still in flight
  always_comb begin
    w_start     = 1'b0;
    w_rd_step   = 1'b0;
    w_wr_step   = 1'b0;
    w_deposit   = 1'b0;
    w_fill_done = 1'b0;
    w_wb_done   = 1'b0;
    case (r_state)
      ST_IDLE: w_start = missIn;
      ST_READ: begin
        w_rd_step   = (r_cnt < LAST_IDX);
        w_deposit   = (r_cnt >= RD_LAT);
        w_fill_done = (r_cnt == FILL_END);
      end
      ST_WRITE: begin
        w_wb_done = (r_cnt == LAST_IDX);
        w_wr_step = (r_cnt != LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      ramAddr      <= '0;
      ramDataOut   <= '0;
      ramWrite     <= 1'b0;
      memDataValid <= 1'b0;
      acceptWrite  <= 1'b0;
      memAddr      <= '0;
      memDataOut   <= '0;
    end else begin
      memDataValid <= w_fill_done;
      acceptWrite  <= w_wb_done;
      if (w_start) begin
        r_addr     <= missAddrIn;
        r_cnt      <= '0;
        ramAddr    <= {missAddrIn, {BLOCK_WIDTH{1'b0}}};
        ramWrite   <= !readWriteIn;
        ramDataOut <= writeBackIn[7:0];
      end else begin
        if (r_state == ST_READ || r_state == ST_WRITE) begin
          r_cnt <= r_cnt + 1'b1;
        end
        ramWrite <= w_wr_step;
        if (w_rd_step || w_wr_step) begin
          ramAddr <= {r_addr, w_next_idx};
        end
        if (w_wr_step) begin
          ramDataOut <= w_wb_byte;
        end
      end
      if (w_fill_done || w_wb_done) begin
        memAddr <= r_addr;
      end
      if (w_fill_done) begin
        memDataOut <= w_line_nxt;
      end
    end
  end

  dcache_mem_ctrl_line_byte_shifter u_line (
    .i_clk       (clkIn),
    .i_resetn    (resetIn),
    .i_load      (w_start),
    .i_load_data (writeBackIn),
    .i_wr_en     (w_deposit),
    .i_wr_idx    (w_cap_idx),
    .i_wr_byte   (ramDataIn),
    .i_rd_idx    (w_next_idx),
    .o_rd_byte   (w_wb_byte),
    .o_line_nxt  (w_line_nxt)
  );

`ifdef DCACHE_MEM_CTRL_PERF_EN
  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      fillCount      <= '0;
      writeBackCount <= '0;
    end else begin
      if (w_fill_done) fillCount <= fillCount + 32'd1;
      if (w_wb_done)   writeBackCount <= writeBackCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb/tb_dcache_mem_ctrl.sv - randomized bench with byte-RAM and line-memory reference model; honours DCACHE_MEM_CTRL_PERF_EN
module tb_dcache_mem_ctrl;
  import dcache_mem_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetIn;
  logic                  missIn;
  logic [31:BLOCK_WIDTH] missAddrIn;
  logic                  readWriteIn;
  logic [LINE_BITS-1:0]  writeBackIn;
  logic                  memDataValid;
  logic [31:BLOCK_WIDTH] memAddr;
  logic [LINE_BITS-1:0]  memDataOut;
  logic                  acceptWrite;
  logic [7:0]            ramDataIn;
  logic [7:0]            ramDataOut;
  logic [31:0]           ramAddr;
  logic                  ramWrite;
`ifdef DCACHE_MEM_CTRL_PERF_EN
  logic [31:0]           fillCount;
  logic [31:0]           writeBackCount;
`endif

  always #5 clk = ~clk;

  dcache_mem_ctrl dut (
    .clkIn        (clk),
    .resetIn      (resetIn),
    .missIn       (missIn),
    .missAddrIn   (missAddrIn),
    .readWriteIn  (readWriteIn),
    .writeBackIn  (writeBackIn),
    .memDataValid (memDataValid),
    .memAddr      (memAddr),
    .memDataOut   (memDataOut),
    .acceptWrite  (acceptWrite),
    .ramDataIn    (ramDataIn),
    .ramDataOut   (ramDataOut),
    .ramAddr      (ramAddr),
    .ramWrite     (ramWrite)
`ifdef DCACHE_MEM_CTRL_PERF_EN
    ,
    .fillCount      (fillCount),
    .writeBackCount (writeBackCount)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Byte RAM seen by the DUT: 64 KiB, aliased on low address bits, unwritten byte[a] = a[7:0]
  logic [7:0] ram [0:65535];
  bit         ram_valid [0:65535];

  always @(posedge clk) begin
    if (ramWrite) begin
      ram[ramAddr[15:0]]       <= ramDataOut;
      ram_valid[ramAddr[15:0]] <= 1'b1;
    end
    ramDataIn <= ram_valid[ramAddr[15:0]] ? ram[ramAddr[15:0]] : ramAddr[7:0];
  end

  function automatic logic [7:0] ram_rd(input logic [15:0] i);
    return ram_valid[i] ? ram[i] : i[7:0];
  endfunction

  // Reference memory contents the bench expects after each completed write-back
  logic [7:0] ref_mem [0:65535];
  bit         ref_valid [0:65535];

  function automatic logic [7:0] ref_rd(input logic [15:0] i);
    return ref_valid[i] ? ref_mem[i] : i[7:0];
  endfunction

  logic [127:0] last_fill = '0;
  int           n_fill    = 0;
  int           n_wb      = 0;
  logic         both_seen = 1'b0;

  always @(negedge clk) begin
    if (memDataValid && acceptWrite) both_seen <= 1'b1;
  end

  task automatic run_txn(input logic rw, input logic [27:0] a, input logic [127:0] wb,
                         input int drop_at, input int rst_at,
                         input logic hold, input logic nrw, input logic [27:0] na, input logic [127:0] nwb);
    logic [127:0] exp_line;
    logic [31:0]  ba;
    logic         early;
    early = 1'b0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      ba = {a, 4'(k)};
      exp_line[8*k +: 8] = ref_rd(ba[15:0]);
    end
    missIn      = 1'b1;
    readWriteIn = rw;
    missAddrIn  = a;
    writeBackIn = wb;
    @(posedge clk); #1;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      ba = {a, 4'(k)};
      if (k == rst_at) begin
        resetIn = 1'b0;
        missIn  = 1'b0;
        @(posedge clk); #1;
        check("rst_outs", {memDataValid, acceptWrite, ramWrite, ramDataOut, ramAddr, memAddr}, '0);
        check("rst_line", memDataOut, '0);
        resetIn   = 1'b1;
        last_fill = '0;
        n_fill    = 0;
        n_wb      = 0;
        early     = 1'b0;
        repeat (BLOCK_SIZE + 4) begin
          @(posedge clk); #1;
          early |= memDataValid | acceptWrite;
        end
        check("rst_no_pulse", early, 1'b0);
        return;
      end
      check("ram_addr", ramAddr, ba);
      check("ram_write", ramWrite, !rw);
      if (!rw) begin
        check("ram_wdata", ramDataOut, wb[8*k +: 8]);
        ref_mem[ba[15:0]]   = wb[8*k +: 8];
        ref_valid[ba[15:0]] = 1'b1;
      end
      early |= memDataValid | acceptWrite;
      if (k == drop_at) missIn = 1'b0;
      @(posedge clk); #1;
    end
    if (rw) begin
      check("ram_write_tail", ramWrite, 1'b0);
      early |= memDataValid | acceptWrite;
      @(posedge clk); #1;
    end
    check("early_pulse", early, 1'b0);
    check("valid_pulse", memDataValid, rw);
    check("accept_pulse", acceptWrite, !rw);
    check("mem_addr", memAddr, a);
    check("ram_write_end", ramWrite, 1'b0);
    if (rw) begin
      last_fill = exp_line;
      n_fill++;
    end else begin
      n_wb++;
    end
    check("mem_data", memDataOut, last_fill);
    if (hold) begin
      missIn      = 1'b1;
      readWriteIn = nrw;
      missAddrIn  = na;
      writeBackIn = nwb;
    end else begin
      missIn = 1'b0;
    end
    @(posedge clk); #1;
    check("pulse_gone", memDataValid | acceptWrite, 1'b0);
    check("done_ignores_miss", ramAddr, {a, 4'hF});
    if (!rw) begin
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        ba = {a, 4'(k)};
        check("ram_content", ram_rd(ba[15:0]), ref_rd(ba[15:0]));
      end
    end
  endtask

  initial begin
    logic         c_rw, n_rw, hold;
    logic [27:0]  c_a, n_a;
    logic [127:0] c_wb, n_wb2;
    int           drop;

    resetIn     = 1'b0;
    missIn      = 1'b0;
    missAddrIn  = '0;
    readWriteIn = 1'b0;
    writeBackIn = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_outs", {memDataValid, acceptWrite, ramWrite, ramDataOut, ramAddr, memAddr}, '0);
    check("rst_init_line", memDataOut, '0);
    resetIn = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b1, 28'h0000100, '0, -1, -1, 1'b0, 1'b0, '0, '0);
    check("fill_100_line", memDataOut, 128'h0F0E0D0C0B0A09080706050403020100);

    run_txn(1'b0, 28'h0000200, 128'hFFEEDDCCBBAA99887766554433221100, -1, -1, 1'b0, 1'b0, '0, '0);

    c_wb = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 28'h0000300, c_wb, -1, -1, 1'b1, 1'b1, 28'h0000300, '0);
    run_txn(1'b1, 28'h0000300, '0, -1, -1, 1'b0, 1'b0, '0, '0);
    check("b2b_readback", memDataOut, c_wb);

    run_txn(1'b0, 28'h0000400, {$urandom, $urandom, $urandom, $urandom}, 3, -1, 1'b0, 1'b0, '0, '0);

    run_txn(1'b1, 28'hFFFFFFF, '0, -1, -1, 1'b0, 1'b0, '0, '0);

    run_txn(1'b1, 28'h0000500, '0, -1, 7, 1'b0, 1'b0, '0, '0);
    run_txn(1'b1, 28'h0000500, '0, -1, -1, 1'b0, 1'b0, '0, '0);

    c_rw = 1'($urandom_range(0, 1));
    c_a  = 28'($urandom_range(0, 7));
    c_wb = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      n_rw  = 1'($urandom_range(0, 1));
      n_a   = ($urandom_range(0, 1) == 1) ? 28'($urandom_range(0, 7)) : 28'($urandom);
      n_wb2 = {$urandom, $urandom, $urandom, $urandom};
      hold  = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      drop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BLOCK_SIZE - 1)) : -1;
      run_txn(c_rw, c_a, c_wb, drop, -1, hold, n_rw, n_a, n_wb2);
      c_rw = n_rw;
      c_a  = n_a;
      c_wb = n_wb2;
    end

    check("pulses_exclusive", both_seen, 1'b0);
`ifdef DCACHE_MEM_CTRL_PERF_EN
    check("fill_count", fillCount, n_fill);
    check("wb_count", writeBackCount, n_wb);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
